seq_phase_controller: RTL and testbench
=======================================

SEQ_PHASE_CONTROLLER -- requirements
Module: seq_phase_controller

Interface
REQ-001 The block SHALL have parameter ITER_W, default 4, the width of the pass-count request and pass counter.
REQ-002 The block SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
REQ-004 The block SHALL have port start  input  1  request to run an operation, sampled in IDLE, DONE and ERR only.
REQ-005 The block SHALL have port iters  input  ITER_W  number of 5-phase passes requested, latched on accepted start.
REQ-006 The block SHALL have port cycle  input  5  one-hot phase from the modulo-5 sequence counter (bit k = phase k).
REQ-007 The block SHALL have port begin_sig  output  1  set request to the sequence counter's run flip-flop.
REQ-008 The block SHALL have port end_sig  output  1  reset request to the sequence counter's run flip-flop.
REQ-009 The block SHALL have ports load_en, exec_en, write_en  output  1 each  datapath phase strobes.
REQ-010 The block SHALL have port pass_cnt  output  ITER_W  number of completed passes in the current operation.
REQ-011 The block SHALL have ports busy, done, err  output  1 each  status: operation active, completion pulse, phase-error flag.

Function
REQ-012 The FSM SHALL have states IDLE, ARM, RUN, DONE, ERR.
REQ-013 In IDLE or DONE, start=1 SHALL latch iters into iters_q, clear pass_cnt to 0 and go to ARM if iters!=0, else to DONE.
REQ-014 In ERR, start=1 SHALL clear err and behave exactly as REQ-013.
REQ-015 start SHALL be ignored in ARM and RUN.
REQ-016 ARM SHALL last exactly one cycle with begin_sig=1, then go to RUN; begin_sig SHALL be 0 in all other states.
REQ-017 In RUN: load_en=cycle[1], exec_en=cycle[2], write_en=cycle[3], combinationally; all three SHALL be 0 outside RUN; cycle[0] is an idle slot.
REQ-018 In RUN, on a cycle with cycle[4]=1, pass_cnt SHALL increment by 1 at the next edge.
REQ-019 In RUN, when cycle[4]=1 and pass_cnt+1==iters_q (compared at ITER_W+1 bits, no wrap), end_sig SHALL be 1 combinationally that cycle and the FSM SHALL go to DONE.
REQ-020 DONE SHALL last one cycle unless start=1 there (back-to-back, REQ-013); done=1 only in DONE.
REQ-021 busy SHALL be 1 in ARM and RUN, 0 otherwise.
REQ-022 In ARM or RUN, if cycle is not exactly one-hot (zero or multiple bits set), the FSM SHALL go to ERR at the next edge, without incrementing pass_cnt and with all strobes 0 that cycle.
REQ-023 In ERR: err=1, end_sig=1 continuously, strobes 0, busy 0; pass_cnt holds its value.
REQ-024 One-hot check SHALL take priority over REQ-018/REQ-019 in the same cycle.
REQ-025 iters=2^ITER_W-1 SHALL run 15 passes (ITER_W=4) with no pass_cnt overflow.

Reset
REQ-026 reset=0 SHALL force state IDLE, pass_cnt=0, iters_q=0, and all outputs 0, asynchronously, including mid-operation.
REQ-027 After reset release, the first accepted start SHALL behave per REQ-013; no output SHALL pulse on release.

Verification
REQ-028 Reset, start=1 iters=1, counter model driven by begin_sig/end_sig -> begin_sig 1 cycle, RUN sees cycle 00001..10000, strobes on phases 1/2/3, end_sig with cycle=10000, done 1 cycle, pass_cnt=1.
REQ-029 start iters=3 -> exactly 15 RUN cycles, 3 each of load_en/exec_en/write_en, pass_cnt 1,2,3, single end_sig, done.
REQ-030 start iters=0 -> DONE next cycle, begin_sig never 1, busy never 1, pass_cnt=0.
REQ-031 Force cycle=00110 during RUN pass 2 -> ERR next cycle, err=1, end_sig=1 held, pass_cnt=1; then start iters=1 -> err=0, normal run.
REQ-032 Pulse reset low mid-RUN at cycle=00100 -> all outputs 0 immediately; start held high in RUN ignored; start in DONE with iters=2 -> ARM directly (back-to-back).

Source files
------------

// File: rtl/seq_phase_controller.sv
// seq_phase_controller: sequences multi-pass operations over a one-hot 5-phase cycle counter
module seq_phase_controller #(
  parameter int ITER_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] iters,
  input  logic [4:0]        cycle,
  output logic              begin_sig,
  output logic              end_sig,
  output logic              load_en,
  output logic              exec_en,
  output logic              write_en,
  output logic [ITER_W-1:0] pass_cnt,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, ARM, RUN, DONE, ERR} state_t;
  state_t            state;
  logic [ITER_W-1:0] iters_q;
  logic              one_hot;
  logic              in_run;
  logic              last;
  // A zero or multi-bit phase vector suppresses every strobe and the pass increment
  assign one_hot  = (cycle != '0) && ((cycle & (cycle - 5'd1)) == '0);
  assign in_run   = (state == RUN) && one_hot;
  // Extra top bit keeps the final-pass compare exact for iters = all ones
  assign last     = ({1'b0, pass_cnt} + (ITER_W + 1)'(1)) == {1'b0, iters_q};
  assign load_en  = in_run & cycle[1];
  assign exec_en  = in_run & cycle[2];
  assign write_en = in_run & cycle[3];
  assign end_sig  = err | (in_run & cycle[4] & last);
  // Control FSM with registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      iters_q   <= '0;
      pass_cnt  <= '0;
      begin_sig <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      begin_sig <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            iters_q  <= iters;
            pass_cnt <= '0;
            err      <= 1'b0;
            if (iters != '0) begin
              state     <= ARM;
              begin_sig <= 1'b1;
              busy      <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        ARM: begin
          if (!one_hot) begin
            state <= ERR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!one_hot) begin
            state <= ERR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else if (cycle[4]) begin
            pass_cnt <= pass_cnt + ITER_W'(1);
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_phase_controller.sv
// tb_seq_phase_controller: randomized self-checking bench with a phase-counter model and count-based reference
module tb_seq_phase_controller;
  localparam int W = 4;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, force_en = 1'b0, cnt_run;
  logic [W-1:0] iters = '0;
  logic [4:0] cyc_cnt, cyc_force = '0, cycle;
  logic begin_sig, end_sig, load_en, exec_en, write_en, busy, done, err;
  logic [W-1:0] pass_cnt;
  int n_cmp = 0, n_fail = 0;
  int m_begin, m_busy, m_load, m_exec, m_write, m_end, m_done, m_pc, m_sbad, m_ebad;

  seq_phase_controller #(.ITER_W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .iters(iters), .cycle(cycle),
    .begin_sig(begin_sig), .end_sig(end_sig), .load_en(load_en), .exec_en(exec_en),
    .write_en(write_en), .pass_cnt(pass_cnt), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  assign cycle = force_en ? cyc_force : cyc_cnt;

  // Modulo-5 sequence counter: begin_sig sets its run flip-flop, end_sig clears it and rewinds to phase 0
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_run <= 1'b0;
      cyc_cnt <= 5'b00001;
    end else if (end_sig) begin
      cnt_run <= 1'b0;
      cyc_cnt <= 5'b00001;
    end else begin
      if (begin_sig) cnt_run <= 1'b1;
      if (cnt_run) cyc_cnt <= {cyc_cnt[3:0], cyc_cnt[4]};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one start and tally every output until done or the cycle budget runs out
  task automatic run_op(input int n, input int budget);
    iters = W'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    {m_begin, m_busy, m_load, m_exec, m_write, m_end, m_done, m_pc, m_sbad, m_ebad} = '0;
    for (int i = 0; i < budget; i++) begin
      m_begin += int'(begin_sig);
      m_busy  += int'(busy);
      m_load  += int'(load_en);
      m_exec  += int'(exec_en);
      m_write += int'(write_en);
      m_end   += int'(end_sig);
      if ((load_en && cycle != 5'b00010) || (exec_en && cycle != 5'b00100) || (write_en && cycle != 5'b01000)) m_sbad++;
      if (end_sig && cycle != 5'b10000) m_ebad++;
      if (done) begin
        m_done = 1;
        m_pc = int'(pass_cnt);
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if ({begin_sig, end_sig, load_en, exec_en, write_en, busy, done, err} !== 8'h00) begin n_fail++; $display("FAIL rst_outputs got %b exp 00000000", {begin_sig, end_sig, load_en, exec_en, write_en, busy, done, err}); end
    n_cmp++; if (pass_cnt !== '0) begin n_fail++; $display("FAIL rst_pass_cnt got %0d exp 0", pass_cnt); end
    step();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if ({begin_sig, end_sig, busy, done, err} !== 5'b0) begin n_fail++; $display("FAIL rst_release_pulse got %b exp 00000", {begin_sig, end_sig, busy, done, err}); end
  endtask

  task automatic test_single();
    run_op(1, 20);
    n_cmp++; if (m_begin !== 1) begin n_fail++; $display("FAIL one_begin got %0d exp 1", m_begin); end
    n_cmp++; if (m_busy !== 6) begin n_fail++; $display("FAIL one_busy got %0d exp 6", m_busy); end
    n_cmp++; if ({m_load, m_exec, m_write} !== {32'd1, 32'd1, 32'd1}) begin n_fail++; $display("FAIL one_strobes got %0d/%0d/%0d exp 1/1/1", m_load, m_exec, m_write); end
    n_cmp++; if (m_end !== 1 || m_ebad !== 0) begin n_fail++; $display("FAIL one_end got %0d bad %0d exp 1 bad 0", m_end, m_ebad); end
    n_cmp++; if (m_sbad !== 0) begin n_fail++; $display("FAIL one_strobe_phase got %0d exp 0", m_sbad); end
    n_cmp++; if (m_done !== 1 || m_pc !== 1) begin n_fail++; $display("FAIL one_done got done %0d pc %0d exp 1 1", m_done, m_pc); end
    step();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL one_done_pulse got done %b busy %b exp 0 0", done, busy); end
  endtask

  task automatic test_iters3();
    run_op(3, 40);
    n_cmp++; if (m_busy - m_begin !== 15) begin n_fail++; $display("FAIL three_run_cycles got %0d exp 15", m_busy - m_begin); end
    n_cmp++; if ({m_load, m_exec, m_write} !== {32'd3, 32'd3, 32'd3}) begin n_fail++; $display("FAIL three_strobes got %0d/%0d/%0d exp 3/3/3", m_load, m_exec, m_write); end
    n_cmp++; if (m_end !== 1 || m_done !== 1 || m_pc !== 3) begin n_fail++; $display("FAIL three_end got end %0d done %0d pc %0d exp 1 1 3", m_end, m_done, m_pc); end
  endtask

  task automatic test_zero();
    run_op(0, 1);
    n_cmp++; if (m_done !== 1) begin n_fail++; $display("FAIL zero_done got %0d exp 1", m_done); end
    n_cmp++; if (m_begin !== 0 || m_busy !== 0 || m_pc !== 0) begin n_fail++; $display("FAIL zero_quiet got begin %0d busy %0d pc %0d exp 0 0 0", m_begin, m_busy, m_pc); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      int n = (k == 0) ? 15 : int'($urandom_range(0, 15));
      run_op(n, 100);
      n_cmp++; if (m_busy !== (n == 0 ? 0 : 1 + 5 * n)) begin n_fail++; $display("FAIL rand_busy n=%0d got %0d exp %0d", n, m_busy, n == 0 ? 0 : 1 + 5 * n); end
      n_cmp++; if (m_load !== n || m_exec !== n || m_write !== n || m_sbad !== 0) begin n_fail++; $display("FAIL rand_strobes n=%0d got %0d/%0d/%0d bad %0d", n, m_load, m_exec, m_write, m_sbad); end
      n_cmp++; if (m_done !== 1 || m_pc !== n || m_end !== (n != 0 ? 1 : 0)) begin n_fail++; $display("FAIL rand_done n=%0d got done %0d pc %0d end %0d", n, m_done, m_pc, m_end); end
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  task automatic test_error(input int n, input int p, input int ph, input logic [4:0] bad);
    int found = 0;
    iters = W'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy && !begin_sig && pass_cnt == W'(p) && cyc_cnt == (5'b1 << ph)) begin found = 1; break; end
      step();
    end
    n_cmp++; if (found !== 1) begin n_fail++; $display("FAIL err_reach got %0d exp 1", found); end
    force_en = 1'b1;
    cyc_force = bad;
    #1;
    n_cmp++; if ({load_en, exec_en, write_en, end_sig} !== 4'b0) begin n_fail++; $display("FAIL err_strobes bad=%b got %b exp 0000", bad, {load_en, exec_en, write_en, end_sig}); end
    step();
    force_en = 1'b0;
    n_cmp++; if ({err, end_sig, busy, done} !== 4'b1100) begin n_fail++; $display("FAIL err_enter got %b exp 1100", {err, end_sig, busy, done}); end
    n_cmp++; if (pass_cnt !== W'(p)) begin n_fail++; $display("FAIL err_pass_cnt got %0d exp %0d", pass_cnt, p); end
    start = 1'b0;
    repeat (3) step();
    n_cmp++; if ({err, end_sig, pass_cnt} !== {2'b11, W'(p)}) begin n_fail++; $display("FAIL err_hold got err %b end %b pc %0d exp 1 1 %0d", err, end_sig, pass_cnt, p); end
    run_op(1, 20);
    n_cmp++; if (err !== 1'b0 || m_done !== 1 || m_pc !== 1 || m_end !== 1) begin n_fail++; $display("FAIL err_recover got err %b done %0d pc %0d end %0d", err, m_done, m_pc, m_end); end
  endtask

  task automatic test_arm_error();
    iters = W'(2);
    start = 1'b1;
    step();
    start = 1'b0;
    force_en = 1'b1;
    cyc_force = 5'b00000;
    #1;
    n_cmp++; if ({begin_sig, load_en, exec_en, write_en} !== 4'b1000) begin n_fail++; $display("FAIL arm_err_strobes got %b exp 1000", {begin_sig, load_en, exec_en, write_en}); end
    step();
    force_en = 1'b0;
    n_cmp++; if ({err, end_sig, busy, begin_sig} !== 4'b1100 || pass_cnt !== '0) begin n_fail++; $display("FAIL arm_err got %b pc %0d exp 1100 pc 0", {err, end_sig, busy, begin_sig}, pass_cnt); end
    run_op(0, 1);
    n_cmp++; if (err !== 1'b0 || m_done !== 1) begin n_fail++; $display("FAIL arm_err_clear got err %b done %0d exp 0 1", err, m_done); end
  endtask

  task automatic test_back_to_back();
    int found = 0, nb = 0, got_done = 0;
    iters = W'(3);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy && cycle == 5'b00100) begin found = 1; break; end
      step();
    end
    reset = 1'b0;
    #1;
    n_cmp++; if (found !== 1 || {begin_sig, end_sig, load_en, exec_en, write_en, busy, done, err} !== 8'h00 || pass_cnt !== '0) begin n_fail++; $display("FAIL midrun_reset found %0d got %b pc %0d exp 00000000 pc 0", found, {begin_sig, end_sig, load_en, exec_en, write_en, busy, done, err}, pass_cnt); end
    step();
    reset = 1'b1;
    step();
    n_cmp++; if ({begin_sig, end_sig, busy, done, err} !== 5'b0) begin n_fail++; $display("FAIL midrun_release got %b exp 00000", {begin_sig, end_sig, busy, done, err}); end
    iters = W'(2);
    start = 1'b1;
    step();
    for (int i = 0; i < 40; i++) begin
      nb += int'(busy);
      if (done) begin got_done = 1; break; end
      step();
    end
    n_cmp++; if (got_done !== 1 || nb !== 11 || pass_cnt !== W'(2)) begin n_fail++; $display("FAIL held_start got done %0d busy %0d pc %0d exp 1 11 2", got_done, nb, pass_cnt); end
    step();
    start = 1'b0;
    n_cmp++; if ({begin_sig, busy, done} !== 3'b110 || pass_cnt !== '0) begin n_fail++; $display("FAIL b2b_arm got %b pc %0d exp 110 pc 0", {begin_sig, busy, done}, pass_cnt); end
    got_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin got_done = 1; break; end
      step();
    end
    n_cmp++; if (got_done !== 1 || pass_cnt !== W'(2)) begin n_fail++; $display("FAIL b2b_done got done %0d pc %0d exp 1 2", got_done, pass_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_iters3();
    test_zero();
    test_random();
    test_error(3, 1, 2, 5'b00110);
    for (int k = 0; k < 4; k++) begin
      int n = int'($urandom_range(2, 6));
      int p = int'($urandom_range(0, n - 1));
      int ph = int'($urandom_range(0, 4));
      logic [4:0] bad = (k == 0) ? 5'b00000 : 5'b11000 | 5'($urandom_range(0, 7));
      test_error(n, p, ph, bad);
    end
    test_arm_error();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
